tinker_regfile_sb: RTL and testbench

Parametrised register file with integrated scoreboard, the next-generation register file for the pipelined tinker core. It provides NRD combinational read ports, one write-back port with optional same-cycle write-to-read bypass, and per-register pending bits set at issue and cleared at write-back or squash. It drives an issue handshake so decode can stall on RAW and WAW hazards without external compare logic. It sits between decode (read/issue) and the MEM/WB stage (write-back/kill).

---
 rtl/tinker_pkg.sv | 13 +
 rtl/tinker_scoreboard.sv | 68 ++++++
 rtl/tinker_regfile_sb.sv | 77 +++++++
 tb/tb_tinker_regfile_sb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared constants and types for the tinker core register file and scoreboard.
package tinker_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned AW       = $clog2(NREGS);
  localparam int unsigned SP_IDX   = 31;
  localparam logic [XLEN-1:0] SP_RESET = 64'd524288;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/tinker_scoreboard.sv
// Pending-bit scoreboard: one in-flight writer per register, RAW/WAW issue
// stall, and a registered count of pending registers.
module tinker_scoreboard
  import tinker_pkg::*;
#(
  parameter int unsigned NREGS  = tinker_pkg::NREGS,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned NRD    = 3,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CW     = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic              iss_wen,
  input  logic [AW-1:0]     iss_dst,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic              kill_valid,
  input  logic [AW-1:0]     kill_addr,
  output logic [CW-1:0]     busy_count
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             dst_busy;
  logic             iss_fire;
  logic [CW-1:0]    count_d;

  // Issue handshake: an instruction issues on a clk edge where iss_valid and
  // iss_ready are both high; iss_ready never depends on iss_valid, and when
  // iss_valid is low iss_ready is only advisory.
  always_comb begin
    rd_busy  = '0;
    dst_busy = pending_q[iss_dst];
    if (BYPASS && wb_valid && (wb_addr == iss_dst)) dst_busy = 1'b0;
    for (int i = 0; i < int'(NRD); i++) begin
      rd_busy[i] = pending_q[rd_addr[i*AW +: AW]];
      if (BYPASS && wb_valid && (wb_addr == rd_addr[i*AW +: AW])) rd_busy[i] = 1'b0;
    end
    iss_ready = !reset && !(|rd_busy) && !(iss_wen && dst_busy);
    iss_fire  = iss_valid && iss_ready;
  end

  // Clears first so a same-edge issue to the same index leaves it pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid)           pending_d[wb_addr]   = 1'b0;
    if (kill_valid)         pending_d[kill_addr] = 1'b0;
    if (iss_fire && iss_wen) pending_d[iss_dst]  = 1'b1;
    count_d = '0;
    for (int i = 0; i < int'(NREGS); i++) count_d = count_d + CW'(pending_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      busy_count <= '0;
    end else begin
      pending_q  <= pending_d;
      busy_count <= count_d;
    end
  end

endmodule

// File: rtl/tinker_regfile_sb.sv
// Register file with combinational read ports, one write-back port with
// optional same-cycle forwarding, and an integrated issue scoreboard.
module tinker_regfile_sb
  import tinker_pkg::*;
#(
  parameter int unsigned     XLEN     = tinker_pkg::XLEN,
  parameter int unsigned     NREGS    = tinker_pkg::NREGS,
  parameter int unsigned     AW       = $clog2(NREGS),
  parameter int unsigned     NRD      = 3,
  parameter int unsigned     SP_IDX   = tinker_pkg::SP_IDX,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(524288),
  parameter bit              BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD*AW-1:0]        rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  output logic [NRD-1:0]           rd_busy,
  output logic [XLEN-1:0]          sp_out,
  input  logic                     iss_valid,
  input  logic                     iss_wen,
  input  logic [AW-1:0]            iss_dst,
  output logic                     iss_ready,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     kill_valid,
  input  logic [AW-1:0]            kill_addr,
  output logic [$clog2(NREGS+1)-1:0] busy_count
);

  localparam logic [AW-1:0] SP_A = AW'(SP_IDX);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++)
        regs_q[i] <= (i == int'(SP_IDX)) ? SP_RESET : '0;
    end else if (wb_valid) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
      if (BYPASS && wb_valid && (wb_addr == rd_addr[i*AW +: AW]))
        rd_data[i*XLEN +: XLEN] = wb_data;
    end
    sp_out = regs_q[SP_A];
    if (BYPASS && wb_valid && (wb_addr == SP_A)) sp_out = wb_data;
  end

  tinker_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .iss_valid  (iss_valid),
    .iss_wen    (iss_wen),
    .iss_dst    (iss_dst),
    .iss_ready  (iss_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .kill_valid (kill_valid),
    .kill_addr  (kill_addr),
    .busy_count (busy_count)
  );

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Directed bench for tinker_regfile_sb: reset, RAW bypass, WAW stall,
// same-edge wb/issue/kill interactions and reset during activity.
module tb_tinker_regfile_sb;
  import tinker_pkg::*;

  localparam int NRD = 3;
  localparam int CW  = $clog2(NREGS + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [XLEN-1:0]       sp_out;
  logic                  iss_valid;
  logic                  iss_wen;
  reg_idx_t              iss_dst;
  logic                  iss_ready;
  logic                  wb_valid;
  reg_idx_t              wb_addr;
  word_t                 wb_data;
  logic                  kill_valid;
  reg_idx_t              kill_addr;
  logic [CW-1:0]         busy_count;

  int compared   = 0;
  int mismatched = 0;

  tinker_regfile_sb dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .sp_out     (sp_out),
    .iss_valid  (iss_valid),
    .iss_wen    (iss_wen),
    .iss_dst    (iss_dst),
    .iss_ready  (iss_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .kill_valid (kill_valid),
    .kill_addr  (kill_addr),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then leave inputs one time unit clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    iss_valid = 0; iss_wen = 0; iss_dst = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    kill_valid = 0; kill_addr = '0;
    rd_addr = '0;
  endtask

  function automatic logic [63:0] rdat(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    idle();
    reset = 1;
    #2;
    check("ready_in_reset", 64'(iss_ready), 64'd0);
    step();
    reset = 0;
    #1;

    // Reset state of every register
    for (int i = 0; i < int'(NREGS); i++) begin
      set_rd(0, i);
      #1;
      check($sformatf("reset_r%0d", i), rdat(0), (i == 31) ? 64'd524288 : 64'd0);
    end
    set_rd(0, 0);
    #1;
    check("reset_sp_out", sp_out, 64'd524288);
    check("reset_ready", 64'(iss_ready), 64'd1);
    check("reset_busy_count", 64'(busy_count), 64'd0);

    // RAW with bypass on r5
    iss_valid = 1; iss_wen = 1; iss_dst = 5;
    #1;
    check("raw_issue_ready", 64'(iss_ready), 64'd1);
    step();
    idle();
    set_rd(0, 5);
    #1;
    check("raw_busy", 64'(rd_busy[0]), 64'd1);
    check("raw_stall", 64'(iss_ready), 64'd0);
    check("raw_count1", 64'(busy_count), 64'd1);
    wb_valid = 1; wb_addr = 5; wb_data = 64'hDEAD;
    #1;
    check("raw_bypass_data", rdat(0), 64'hDEAD);
    check("raw_bypass_busy", 64'(rd_busy[0]), 64'd0);
    check("raw_bypass_ready", 64'(iss_ready), 64'd1);
    step();
    idle();
    set_rd(0, 5);
    #1;
    check("raw_stored", rdat(0), 64'hDEAD);
    check("raw_count0", 64'(busy_count), 64'd0);

    // WAW stall on r7
    iss_valid = 1; iss_wen = 1; iss_dst = 7;
    step();
    #1;
    check("waw_stall0", 64'(iss_ready), 64'd0);
    check("waw_count1", 64'(busy_count), 64'd1);
    step();
    check("waw_stall1", 64'(iss_ready), 64'd0);
    iss_valid = 0;
    wb_valid = 1; wb_addr = 7; wb_data = 64'h77;
    #1;
    check("waw_wb_ready", 64'(iss_ready), 64'd1);
    step();
    wb_valid = 0;
    #1;
    check("waw_count0", 64'(busy_count), 64'd0);
    check("waw_ready_after", 64'(iss_ready), 64'd1);

    // Same-edge wb and issue on r3
    idle();
    wb_valid = 1; wb_addr = 3; wb_data = 64'h11;
    iss_valid = 1; iss_wen = 1; iss_dst = 3;
    step();
    idle();
    set_rd(0, 3);
    #1;
    check("wbiss_data", rdat(0), 64'h11);
    check("wbiss_busy", 64'(rd_busy[0]), 64'd1);
    check("wbiss_count", 64'(busy_count), 64'd1);
    kill_valid = 1; kill_addr = 3;
    step();
    kill_valid = 0;
    #1;
    check("kill_r3_count", 64'(busy_count), 64'd0);
    check("kill_r3_data", rdat(0), 64'h11);

    // Kill of an issued r9 holding 5
    idle();
    wb_valid = 1; wb_addr = 9; wb_data = 64'h5;
    step();
    idle();
    iss_valid = 1; iss_wen = 1; iss_dst = 9;
    step();
    idle();
    set_rd(1, 9);
    #1;
    check("kill_pre_busy", 64'(rd_busy[1]), 64'd1);
    kill_valid = 1; kill_addr = 9;
    step();
    kill_valid = 0;
    #1;
    check("kill_busy", 64'(rd_busy[1]), 64'd0);
    check("kill_data", rdat(1), 64'h5);
    check("kill_count", 64'(busy_count), 64'd0);

    // wb and kill to the same pending index r10
    idle();
    iss_valid = 1; iss_wen = 1; iss_dst = 10;
    step();
    idle();
    wb_valid = 1; wb_addr = 10; wb_data = 64'hAA;
    kill_valid = 1; kill_addr = 10;
    step();
    idle();
    set_rd(2, 10);
    #1;
    check("wbkill_data", rdat(2), 64'hAA);
    check("wbkill_busy", 64'(rd_busy[2]), 64'd0);
    check("wbkill_count", 64'(busy_count), 64'd0);

    // kill and issue to the same index r11
    kill_valid = 1; kill_addr = 11;
    iss_valid = 1; iss_wen = 1; iss_dst = 11;
    step();
    idle();
    set_rd(2, 11);
    #1;
    check("killiss_busy", 64'(rd_busy[2]), 64'd1);
    check("killiss_count", 64'(busy_count), 64'd1);
    kill_valid = 1; kill_addr = 11;
    step();
    idle();

    // Reset during activity
    iss_valid = 1; iss_wen = 1; iss_dst = 2;
    step();
    iss_dst = 4;
    step();
    iss_dst = 31;
    step();
    idle();
    #1;
    check("mid_count3", 64'(busy_count), 64'd3);
    wb_valid = 1; wb_addr = 31; wb_data = 64'h100;
    step();
    idle();
    #1;
    check("mid_sp_written", sp_out, 64'h100);
    check("mid_count2", 64'(busy_count), 64'd2);
    reset = 1;
    wb_valid = 1; wb_addr = 2; wb_data = 64'hFF;
    iss_valid = 1; iss_wen = 1; iss_dst = 6;
    #1;
    check("mid_ready_in_reset", 64'(iss_ready), 64'd0);
    step();
    reset = 0;
    idle();
    set_rd(0, 2); set_rd(1, 4); set_rd(2, 6);
    #1;
    check("mid_count0", 64'(busy_count), 64'd0);
    check("mid_busy", 64'(rd_busy), 64'd0);
    check("mid_r2", rdat(0), 64'd0);
    check("mid_sp", sp_out, 64'd524288);
    check("mid_ready", 64'(iss_ready), 64'd1);
    step();
    check("mid_r6_stays_idle", 64'(busy_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
